// File: rtl/mean7x7_frame_ctrl.sv
// mean7x7_frame_ctrl: frame sequencer in front of the mean7x7 window filter.
// Accepts pixels over valid/ready, issues them to the filter as single-cycle
// gray_valid strobes spaced at least PIX_GAP cycles apart, tracks row/column,
// counts filter outputs and ends the frame with done or a drain timeout.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 one-cycle frame start (honoured only when idle)
//   s_valid/s_ready/s_data  upstream pixel handshake
//   gray_valid/gray       pixel strobe and data to the filter
//   filt_rst              filter reset request (high while idle and clearing)
//   mean_valid            filter output strobe
//   busy, done, timeout_err  frame status
//   in_row/in_col         coordinates of the pixel most recently issued
//   out_cnt               filter outputs counted this frame (saturating)
module mean7x7_frame_ctrl #(
    parameter int unsigned IMAGE_WIDTH   = 320,
    parameter int unsigned IMAGE_HEIGHT  = 240,
    parameter int unsigned PIX_GAP       = 11,
    parameter int unsigned DRAIN_TIMEOUT = 1000000,
    parameter int unsigned CW            = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [7:0]    s_data,
    output logic          gray_valid,
    output logic [7:0]    gray,
    output logic          filt_rst,
    input  logic          mean_valid,
    output logic          busy,
    output logic          done,
    output logic          timeout_err,
    output logic [15:0]   in_row,
    output logic [15:0]   in_col,
    output logic [CW-1:0] out_cnt
);

    localparam int unsigned TOTAL = (IMAGE_WIDTH - 6) * (IMAGE_HEIGHT - 6);
    localparam int unsigned GW    = (PIX_GAP > 1) ? $clog2(PIX_GAP) : 1;
    localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
    localparam logic [CW-1:0] TO_LAST = CW'(DRAIN_TIMEOUT - 1);
    localparam logic [15:0]   COL_LAST = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0]   ROW_LAST = 16'(IMAGE_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, CLR, FEED, DRAIN} state_t;

    state_t        state_q, state_d;
    logic          clr_cnt;
    logic [GW-1:0] gap_q, gap_d;
    logic [CW-1:0] to_cnt;
    logic [CW-1:0] out_cnt_d;
    logic [15:0]   nxt_row, nxt_col;
    logic          xfer, last_pix, start_ok, cnt_inc, met;
    logic          done_d, terr_set;

    assign xfer     = s_valid & s_ready;
    assign last_pix = (nxt_row == ROW_LAST) && (nxt_col == COL_LAST);
    assign start_ok = (state_q == IDLE) && start;
    assign cnt_inc  = mean_valid && (state_q != IDLE) && (out_cnt != TOTAL_C);
    // A strobe landing on the completing cycle is included via out_cnt_d.
    assign met      = (out_cnt_d == TOTAL_C);

    // Next output count and pixel-spacing counter
    always_comb begin
        out_cnt_d = out_cnt;
        gap_d     = gap_q;
        if (start_ok) begin
            out_cnt_d = '0;
            gap_d     = '0;
        end else begin
            if (cnt_inc) out_cnt_d = out_cnt + CW'(1);
            if (xfer) gap_d = GW'(PIX_GAP - 1);
            else if (gap_q != '0) gap_d = gap_q - GW'(1);
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; completion takes priority over timeout
    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        terr_set = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = CLR;
            CLR:   if (clr_cnt) state_d = FEED;
            FEED:  if (xfer && last_pix) state_d = DRAIN;
            DRAIN: begin
                if (met) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (to_cnt == TO_LAST) begin
                    terr_set = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt     <= 1'b0;
            gap_q       <= '0;
            to_cnt      <= '0;
            nxt_row     <= '0;
            nxt_col     <= '0;
            s_ready     <= 1'b0;
            gray_valid  <= 1'b0;
            gray        <= '0;
            filt_rst    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            in_row      <= '0;
            in_col      <= '0;
            out_cnt     <= '0;
        end else begin
            clr_cnt    <= (state_q == CLR) && !clr_cnt;
            gap_q      <= gap_d;
            to_cnt     <= (state_q == DRAIN) ? to_cnt + CW'(1) : '0;
            s_ready    <= (state_d == FEED) && (gap_d == '0);
            gray_valid <= xfer;
            filt_rst   <= (state_d == IDLE) || (state_d == CLR);
            busy       <= (state_d != IDLE);
            done       <= done_d;
            out_cnt    <= out_cnt_d;

            if (start_ok) begin
                nxt_row <= '0;
                nxt_col <= '0;
                in_row  <= '0;
                in_col  <= '0;
            end else if (xfer) begin
                gray   <= s_data;
                in_row <= nxt_row;
                in_col <= nxt_col;
                if (nxt_col == COL_LAST) begin
                    nxt_col <= '0;
                    nxt_row <= nxt_row + 16'd1;
                end else begin
                    nxt_col <= nxt_col + 16'd1;
                end
            end

            if (start_ok)      timeout_err <= 1'b0;
            else if (terr_set) timeout_err <= 1'b1;
        end
    end

endmodule
